// File: rtl/pe_pkg.sv
// Shared types and default widths for the PE column datapath and its output collector.
package pe_pkg;

   localparam int OWIDTH_DEF = 24;
   localparam int OUTW_DEF   = 16;
   localparam int DEPTH_DEF  = 4;
   localparam int KWIDTH_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CLEAR   = 2'd1,
      S_ACCUM   = 2'd2,
      S_CAPTURE = 2'd3
   } ofm_state_e;

endpackage

// File: rtl/ofm_collector_if.sv
// Downstream result stream: out_data is transferred on any cycle where out_valid && out_ready;
// the master holds out_data/out_valid stable while out_valid && !out_ready.
interface ofm_collector_if #(
   parameter int OUTW = pe_pkg::OUTW_DEF
);

   logic [OUTW-1:0] out_data;
   logic            out_valid;
   logic            out_ready;

   modport master (output out_data, output out_valid, input out_ready);
   modport slave  (input out_data, input out_valid, output out_ready);

endinterface

// File: rtl/ofm_collector_fifo.sv
// Synchronous DEPTH-entry result FIFO; head word is shown on the stream, zero when empty.
module ofm_fifo #(
   parameter int W     = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic [W-1:0]             wdata,
   output logic                     push_ok,
   output logic [$clog2(DEPTH):0]   fifo_cnt,
   ofm_collector_if.master          out_if
);

   localparam int PW = $clog2(DEPTH);

   logic [W-1:0]  mem_q [DEPTH];
   logic [W-1:0]  mem_d [DEPTH];
   logic [PW-1:0] rd_ptr_q, rd_ptr_d;
   logic [PW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PW:0]   cnt_q, cnt_d;
   logic          pop;
   logic          do_push;

   // A full FIFO still accepts a push when the head leaves in the same cycle.
   always_comb begin
      pop      = (cnt_q != '0) && out_if.out_ready;
      push_ok  = (cnt_q < (PW+1)'(DEPTH)) || pop;
      do_push  = push && push_ok;
      mem_d    = mem_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + PW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({do_push, pop})
         2'b10:   cnt_d = cnt_q + (PW+1)'(1);
         2'b01:   cnt_d = cnt_q - (PW+1)'(1);
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         cnt_q    <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
         mem_q    <= mem_d;
      end
   end

   assign out_if.out_valid = (cnt_q != '0);
   assign out_if.out_data  = (cnt_q != '0) ? mem_q[rd_ptr_q] : '0;
   assign fifo_cnt         = cnt_q;

endmodule

// File: rtl/ofm_collector.sv
// Output collector for one PE column: clears, accumulates k_len cycles, captures into a FIFO.
// Build option OFM_SAT_EN selects signed saturation instead of truncation of the captured sum.
module ofm_collector
   import pe_pkg::*;
#(
   parameter int OWIDTH = OWIDTH_DEF,
   parameter int OUTW   = OUTW_DEF,
   parameter int DEPTH  = DEPTH_DEF,
   parameter int KWIDTH = KWIDTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [KWIDTH-1:0]          k_len,
   output logic                       en_o,
   output logic                       clr_o,
   input  logic signed [OWIDTH-1:0]   ofm_d,
   ofm_collector_if.master            out_if,
   output logic                       busy,
   output logic                       done,
   output logic [$clog2(DEPTH):0]     fifo_cnt,
   output ofm_state_e                 state_dbg
);

   ofm_state_e        state_q, state_d;
   logic [KWIDTH-1:0] cnt_q, cnt_d;
   logic              push;
   logic              push_ok;
   logic [OUTW-1:0]   out_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // cnt_q holds the cycles of enable still owed, including the current ACCUM cycle.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_CLEAR;
               cnt_d   = k_len;
            end
         end
         S_CLEAR: begin
            state_d = (cnt_q != '0) ? S_ACCUM : S_CAPTURE;
         end
         S_ACCUM: begin
            cnt_d = cnt_q - KWIDTH'(1);
            if (cnt_q == KWIDTH'(1)) begin
               state_d = S_CAPTURE;
            end
         end
         S_CAPTURE: begin
            if (push_ok) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      en_o  = (state_q == S_ACCUM);
      clr_o = (state_q == S_CLEAR);
      busy  = (state_q != S_IDLE);
      push  = (state_q == S_CAPTURE);
      done  = (state_q == S_CAPTURE) && push_ok;
   end

`ifdef OFM_SAT_EN
   localparam logic signed [OWIDTH-1:0] SAT_MAX =
      {{(OWIDTH-OUTW+1){1'b0}}, {(OUTW-1){1'b1}}};
   localparam logic signed [OWIDTH-1:0] SAT_MIN =
      {{(OWIDTH-OUTW+1){1'b1}}, {(OUTW-1){1'b0}}};

   always_comb begin
      if (ofm_d > SAT_MAX) begin
         out_word = SAT_MAX[OUTW-1:0];
      end else if (ofm_d < SAT_MIN) begin
         out_word = SAT_MIN[OUTW-1:0];
      end else begin
         out_word = ofm_d[OUTW-1:0];
      end
   end
`else
   logic unused_ofm_hi;

   assign unused_ofm_hi = ^ofm_d;

   always_comb begin
      out_word = ofm_d[OUTW-1:0];
   end
`endif

   ofm_fifo #(
      .W     (OUTW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .push     (push),
      .wdata    (out_word),
      .push_ok  (push_ok),
      .fifo_cnt (fifo_cnt),
      .out_if   (out_if)
   );

   assign state_dbg = state_q;

endmodule

// File: doc/ofm_collector.md
Name: ofm_collector

Overview:
- Output-side controller for one PE column of the binary-parallel systolic array.
- Drives the accumulator controls (en_o/clr_o) of the column's last PE and reads its ofm_d result after a programmed reduction length.
- Captures each finished sum into a small FIFO and presents it downstream over a valid/ready stream.
- Stalls the PE accumulator rather than dropping a result when the FIFO is full.

Parameters:
- OWIDTH, 24, width of PE accumulator result ofm_d (signed)
- OUTW, 16, width of emitted output word (signed), OUTW <= OWIDTH
- DEPTH, 4, FIFO entries (power of two, >= 2)
- KWIDTH, 8, width of reduction-length field

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start  in  1  one-cycle pulse, begin one reduction; ignored unless idle
- k_len  in  KWIDTH  number of accumulate cycles, sampled on accepted start
- en_o  out  1  accumulator enable to PE
- clr_o  out  1  accumulator clear to PE
- ofm_d  in  OWIDTH  signed accumulated result from PE
- out_data  out  OUTW  signed result word, FIFO head
- out_valid  out  1  FIFO non-empty
- out_ready  in  1  downstream accepts out_data
- busy  out  1  FSM not in IDLE
- done  out  1  one-cycle pulse on the cycle a result is pushed
- fifo_cnt  out  $clog2(DEPTH)+1  current occupancy

Behaviour:
- Reset (rst=1 at clk edge):
  - FSM to IDLE, FIFO emptied, internal counter cleared.
  - Outputs: en_o=0, clr_o=0, out_valid=0, out_data=0, busy=0, done=0, fifo_cnt=0.
  - Reset mid-operation aborts the reduction; any partial PE sum is discarded.
- FSM states: IDLE, CLEAR, ACCUM, CAPTURE.
  - IDLE: en_o=0, clr_o=0. start=1 latches k_len, goes to CLEAR.
  - CLEAR: one cycle, clr_o=1, en_o=0. Next state is ACCUM if latched k_len>0, else CAPTURE.
  - ACCUM: en_o=1 for exactly k_len consecutive cycles; down-counter from k_len; goes to CAPTURE when the counter reaches 1.
  - CAPTURE: en_o=0, clr_o=0. ofm_d now includes all k_len updates (PE acc is registered, one-cycle update).
    - If a push is allowed, write the converted ofm_d into the FIFO, assert done, go to IDLE.
    - Otherwise stay in CAPTURE (the PE holds its sum because en_o=0), done=0.
- start while busy=1: ignored, no queuing.
- k_len=0: CLEAR then CAPTURE; captures the cleared value, 0.
- Cycle count: one reduction takes k_len+2 cycles from the cycle after start to the done pulse, when not stalled. Back-to-back start on the cycle after done gives k_len+3 cycles per result.
- FIFO:
  - Push allowed when fifo_cnt<DEPTH, or when fifo_cnt==DEPTH and a pop occurs in the same cycle.
  - Pop when out_valid && out_ready.
  - Simultaneous push and pop: fifo_cnt unchanged.
  - Pointers wrap modulo DEPTH.
  - out_data is the registered head entry; out_data=0 when empty.
  - out_data and out_valid hold stable while out_valid && !out_ready.
- Conversion ofm_d -> OUTW (in CAPTURE): see Optional Feature.

Optional Feature:
- Macro OFM_SAT_EN.
- Defined: signed saturation of ofm_d to the OUTW range. Values above 2^(OUTW-1)-1 clamp to that maximum; values below -2^(OUTW-1) clamp to that minimum.
- Undefined: plain truncation, out = ofm_d[OUTW-1:0].
- When OUTW==OWIDTH both modes are pass-through.

Decomposition:
- Shared package (pe_pkg): state enum typedef (IDLE, CLEAR, ACCUM, CAPTURE) and the default width constants (OWIDTH=24, OUTW=16) used by pe_inner and the collector.
- Sub-module: ofm_fifo, a synchronous DEPTH-entry valid/ready FIFO with count output.
- The FSM, counter and conversion stay in ofm_collector.

Test Plan:
- Basic reduction: start with k_len=3, PE model with sums 5,7,-2 → clr_o high 1 cycle, en_o high exactly 3 cycles, done pulses 5 cycles after start, out_data=10, out_valid=1.
- Zero length: k_len=0 with ofm_d forced 0 after clr → CLEAR then CAPTURE, out_data=0, done 2 cycles after start.
- FIFO-full stall: out_ready=0, 5 reductions with k_len=1 and DEPTH=4 → fifo_cnt=4, FSM holds CAPTURE with en_o=0 and busy=1. Raising out_ready for 1 cycle pushes the 5th result in the same cycle as the pop, fifo_cnt stays 4, order preserved.
- Saturation (OUTW=16): ofm_d=40000 → 32767 with OFM_SAT_EN, 0x9C40 (-25536) without. ofm_d=-40000 → -32768 with the macro.
- Start while busy and reset abort: start pulse during ACCUM is ignored with no extra result. rst=1 during ACCUM of k_len=10 gives en_o=0 next cycle, fifo_cnt=0, out_valid=0, busy=0.
